// File: rtl/jtag_master.sv
// JTAG master: runs DR/IR scans and TAP resets from a single command port,
// generating TCK from sclk with a CLK_DIV half-period divider.
module jtag_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        TCK,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] TRST  = 3'd1;
    localparam logic [2:0] PRE   = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] POST  = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    typedef struct packed {
        logic        is_ir;
        logic [4:0]  len;
        logic [31:0] data;
    } cmd_t;

    cmd_t       cmd_q;
    logic [2:0] state;
    logic [4:0] cnt;
    logic [7:0] div_cnt;

    logic       active, div_end, rise, fall, accept, last_bit;
    logic [2:0] nxt_state;
    logic [4:0] nxt_cnt;
    logic       nxt_tms, nxt_tdi;

    assign active  = (state == TRST) || (state == PRE) || (state == SHIFT) || (state == POST);
    assign div_end = (div_cnt == DIV_MAX);
    assign rise    = active && div_end && !TCK;
    assign fall    = active && div_end && TCK;
    assign accept  = cmd_valid && cmd_ready;

    always_comb begin
        case (state)
            TRST:    last_bit = (cnt == 5'd5);
            PRE:     last_bit = (cnt == (cmd_q.is_ir ? 5'd3 : 5'd2));
            SHIFT:   last_bit = (cnt == cmd_q.len);
            POST:    last_bit = (cnt == 5'd1);
            default: last_bit = 1'b0;
        endcase
    end

    // Position (state, bit) of the bit-period that starts at the next TCK fall.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 5'd1;
        if (last_bit) begin
            nxt_cnt = 5'd0;
            case (state)
                TRST:    nxt_state = RESP;
                PRE:     nxt_state = SHIFT;
                SHIFT:   nxt_state = POST;
                POST:    nxt_state = RESP;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_comb begin
        nxt_tms = 1'b0;
        nxt_tdi = 1'b0;
        case (nxt_state)
            TRST:  nxt_tms = (nxt_cnt != 5'd5);
            PRE:   nxt_tms = (nxt_cnt == 5'd0) || (cmd_q.is_ir && nxt_cnt == 5'd1);
            SHIFT: begin
                nxt_tms = (nxt_cnt == cmd_q.len);
                nxt_tdi = cmd_q.data[nxt_cnt];
            end
            POST:  nxt_tms = (nxt_cnt == 5'd0);
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            cnt       <= '0;
            div_cnt   <= '0;
            TCK       <= 1'b0;
            TMS       <= 1'b0;
            TDI       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    TCK     <= 1'b0;
                    div_cnt <= '0;
                    cnt     <= '0;
                    if (accept) begin
                        cmd_q     <= '{is_ir: (cmd_op == 2'b01), len: cmd_len, data: cmd_data};
                        state     <= (cmd_op == 2'b10) ? TRST : PRE;
                        TMS       <= 1'b1;
                        TDI       <= 1'b0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b0;
                    end else begin
                        TMS       <= 1'b0;
                        TDI       <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                TRST, PRE, SHIFT, POST: begin
                    div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
                    if (div_end)
                        TCK <= ~TCK;
                    if (rise && state == SHIFT)
                        rsp_data[cnt] <= TDO;
                    // Bit-period boundary: TMS/TDI move to the next bit as TCK falls.
                    if (fall) begin
                        state <= nxt_state;
                        cnt   <= nxt_cnt;
                        TMS   <= nxt_tms;
                        TDI   <= nxt_tdi;
                        if (nxt_state == RESP)
                            rsp_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Scoreboard bench for jtag_master: per-TCK-edge TMS/TDI and response data
// are queued at command issue and compared as the DUT produces them.
module tb_jtag_master;

    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_ready = 1'b1;
    int          tdo_mode = 0;   // 0: TDO=TDI loop, 1: held 1, 2: held 0
    logic        cmd_ready, rsp_valid, TCK, TMS, TDI, TDO;
    logic [31:0] rsp_data;

    logic        va = 1'b0, vb = 1'b0;
    logic        ready_a, rsp_valid_a, tck_a, tms_a, tdi_a;
    logic        ready_b, rsp_valid_b, tck_b, tms_b, tdi_b;
    logic [31:0] rsp_data_a, rsp_data_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_rise = 0;

    logic        exp_tms_q[$];
    logic        exp_tdi_q[$];
    logic [31:0] exp_rsp_q[$];

    assign TDO = (tdo_mode == 0) ? TDI : (tdo_mode == 1);

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc++;

    jtag_master #(.CLK_DIV(2)) dut (
        .sclk(sclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    jtag_master #(.CLK_DIV(1)) dut_a (
        .sclk(sclk), .reset(reset), .cmd_valid(va), .cmd_ready(ready_a),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid_a), .rsp_ready(1'b1), .rsp_data(rsp_data_a),
        .TCK(tck_a), .TMS(tms_a), .TDI(tdi_a), .TDO(tdi_a)
    );

    jtag_master #(.CLK_DIV(4)) dut_b (
        .sclk(sclk), .reset(reset), .cmd_valid(vb), .cmd_ready(ready_b),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid_b), .rsp_ready(1'b1), .rsp_data(rsp_data_b),
        .TCK(tck_b), .TMS(tms_b), .TDI(tdi_b), .TDO(tdi_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the TCK-edge sequences and the captured response.
    function automatic int n_edges(input logic [1:0] op, input logic [4:0] len);
        if (op == 2'b10) return 6;
        return int'(len) + ((op == 2'b01) ? 7 : 6);
    endfunction

    function automatic logic [63:0] tms_vec(input logic [1:0] op, input logic [4:0] len);
        logic [63:0] v = '0;
        int p = (op == 2'b01) ? 4 : 3;
        if (op == 2'b10) return 64'h1F;
        v[0] = 1'b1;
        if (op == 2'b01) v[1] = 1'b1;
        v[p + int'(len)] = 1'b1;
        v[p + int'(len) + 1] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] tdi_vec(input logic [1:0] op, input logic [4:0] len,
                                            input logic [31:0] data);
        logic [63:0] v = '0;
        int p = (op == 2'b01) ? 4 : 3;
        if (op != 2'b10)
            for (int i = 0; i <= int'(len); i++) v[p + i] = data[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_rsp(input logic [1:0] op, input logic [4:0] len,
                                            input logic [31:0] data, input int mode);
        logic [63:0] m = (64'd1 << (int'(len) + 1)) - 64'd1;
        if (op == 2'b10 || mode == 2) return 32'd0;
        return ((mode == 1) ? 32'hFFFF_FFFF : data) & m[31:0];
    endfunction

    task automatic push_exp(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data);
        logic [63:0] t = tms_vec(op, len);
        logic [63:0] d = tdi_vec(op, len, data);
        for (int k = 0; k < n_edges(op, len); k++) begin
            exp_tms_q.push_back(t[k]);
            exp_tdi_q.push_back(d[k]);
        end
        exp_rsp_q.push_back(exp_rsp(op, len, data, tdo_mode));
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data);
        int t = 0;
        while (!cmd_ready && t < 1000) begin
            @(posedge sclk); #1; t++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        push_exp(op, len, data);
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        @(posedge sclk); #1;
        cmd_valid = 1'b0;
        chk("ready_drop", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while ((exp_rsp_q.size() != 0 || !cmd_ready) && t < budget) begin
            @(posedge sclk); #1; t++;
        end
        chk("done_rsp_left", 32'(exp_rsp_q.size()), 32'd0);
        chk("done_edges_left", 32'(exp_tms_q.size()), 32'd0);
        chk("done_ready", 32'(cmd_ready), 32'd1);
    endtask

    logic tck_prev = 1'b0;
    always @(negedge sclk) begin
        if (TCK && !tck_prev) begin
            n_rise++;
            if (exp_tms_q.size() == 0)
                chk("tck_extra_edge", 32'(n_rise), 32'd0);
            else begin
                chk("tms", 32'(TMS), 32'(exp_tms_q.pop_front()));
                chk("tdi", 32'(TDI), 32'(exp_tdi_q.pop_front()));
            end
        end
        tck_prev = TCK;
        chk("ready_and_valid", 32'(cmd_ready & rsp_valid), 32'd0);
        if (rsp_valid) begin
            if (exp_rsp_q.size() == 0)
                chk("rsp_extra", 32'(rsp_valid), 32'd0);
            else begin
                chk("rsp_data", rsp_data, exp_rsp_q[0]);
                if (rsp_ready) void'(exp_rsp_q.pop_front());
            end
        end
    end

    logic [63:0] seq_tms_a = '0, seq_tdi_a = '0, seq_tms_b = '0, seq_tdi_b = '0;
    int          k_a = 0, k_b = 0, last_a = 0, last_b = 0;
    logic [31:0] got_a = '0, got_b = '0;
    logic        done_a = 1'b0, done_b = 1'b0, prev_a = 1'b0, prev_b = 1'b0;

    always @(negedge sclk) begin
        if (tck_a && !prev_a) begin
            if (k_a > 0) chk("period_div1", 32'(cyc - last_a), 32'd2);
            last_a = cyc;
            if (k_a < 64) begin seq_tms_a[k_a] = tms_a; seq_tdi_a[k_a] = tdi_a; end
            k_a++;
        end
        prev_a = tck_a;
        if (rsp_valid_a) begin got_a = rsp_data_a; done_a = 1'b1; end
        if (tck_b && !prev_b) begin
            if (k_b > 0) chk("period_div4", 32'(cyc - last_b), 32'd8);
            last_b = cyc;
            if (k_b < 64) begin seq_tms_b[k_b] = tms_b; seq_tdi_b[k_b] = tdi_b; end
            k_b++;
        end
        prev_b = tck_b;
        if (rsp_valid_b) begin got_b = rsp_data_b; done_b = 1'b1; end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;
        logic [31:0] d;
        logic [63:0] ev;

        #1 reset = 1'b0;
        repeat (3) begin
            @(posedge sclk); #1;
            chk("rst_ctl", 32'({TCK, TMS, TDI, cmd_ready, rsp_valid}), 32'd0);
            chk("rst_data", rsp_data, 32'd0);
        end
        reset = 1'b1;
        @(posedge sclk); #1;
        chk("release_ready", 32'(cmd_ready), 32'd1);

        // DR loopback, IR with TDO high, TAP reset, reserved op, 1-bit scans
        tdo_mode = 0; send(2'b00, 5'd7, 32'h0000_00A5); wait_done(400);
        tdo_mode = 1; send(2'b01, 5'd3, 32'h9);         wait_done(400);
        tdo_mode = 0; send(2'b10, 5'd0, 32'h0);         wait_done(400);
        tdo_mode = 0; send(2'b11, 5'd0, 32'h1);         wait_done(400);
        tdo_mode = 0; send(2'b00, 5'd0, 32'hFFFF_FFFE); wait_done(400);
        tdo_mode = 0; send(2'b00, 5'd31, 32'hC3A5_5A3C); wait_done(400);
        repeat (4) begin
            tdo_mode = $urandom_range(0, 2);
            send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom);
            wait_done(400);
        end

        // Response back-pressure with cmd_valid pulses during the scan
        tdo_mode = 2; rsp_ready = 1'b0;
        send(2'b00, 5'd31, 32'hFFFF_FFFF);
        repeat (20) begin
            @(posedge sclk); #1;
            cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 32'h1234_5678;
            @(posedge sclk); #1;
            cmd_valid = 1'b0;
        end
        t = 0;
        while (!rsp_valid && t < 400) begin @(posedge sclk); #1; t++; end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (20) begin
            @(posedge sclk); #1;
            chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        wait_done(50);

        // Reset around the 10th shift bit of a 32-bit scan
        tdo_mode = 0;
        base = n_rise;
        send(2'b00, 5'd31, $urandom);
        t = 0;
        while (n_rise < base + 13 && t < 400) begin @(posedge sclk); #1; t++; end
        chk("abort_point", 32'(n_rise - base), 32'd13);
        reset = 1'b0;
        exp_tms_q.delete(); exp_tdi_q.delete(); exp_rsp_q.delete();
        #1;
        chk("abort_ctl", 32'({TCK, TMS, TDI, cmd_ready, rsp_valid}), 32'd0);
        repeat (2) begin
            @(posedge sclk); #1;
            chk("abort_ctl_hold", 32'({TCK, TMS, TDI, cmd_ready, rsp_valid}), 32'd0);
            chk("abort_data", rsp_data, 32'd0);
        end
        reset = 1'b1;
        @(posedge sclk); #1;
        chk("abort_release_ready", 32'(cmd_ready), 32'd1);
        repeat (20) @(posedge sclk);
        #1;
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        send(2'b10, 5'd0, 32'h0); wait_done(400);
        send(2'b00, 5'd9, 32'h2B5); wait_done(400);

        // Same DR scan on CLK_DIV=1 and CLK_DIV=4 instances
        d = $urandom;
        @(posedge sclk); #1;
        chk("side_ready", 32'({ready_a, ready_b}), 32'd3);
        cmd_op = 2'b00; cmd_len = 5'd11; cmd_data = d;
        va = 1'b1; vb = 1'b1;
        @(posedge sclk); #1;
        va = 1'b0; vb = 1'b0;
        t = 0;
        while (!(done_a && done_b) && t < 600) begin @(posedge sclk); #1; t++; end
        chk("side_done", 32'({done_a, done_b}), 32'd3);
        chk("side_edges_div1", 32'(k_a), 32'(n_edges(2'b00, 5'd11)));
        chk("side_edges_div4", 32'(k_b), 32'(n_edges(2'b00, 5'd11)));
        ev = tms_vec(2'b00, 5'd11);
        chk("side_tms_div1", seq_tms_a[31:0], ev[31:0]);
        chk("side_tms_div4", seq_tms_b[31:0], ev[31:0]);
        ev = tdi_vec(2'b00, 5'd11, d);
        chk("side_tdi_div1", seq_tdi_a[31:0], ev[31:0]);
        chk("side_tdi_div4", seq_tdi_b[31:0], ev[31:0]);
        chk("side_rsp_div1", got_a, exp_rsp(2'b00, 5'd11, d, 0));
        chk("side_rsp_div4", got_b, exp_rsp(2'b00, 5'd11, d, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
